// File: rtl/mod_add_serial.sv
// mod_add_serial: digit-serial (A + B) mod P for the BLS12-381 base field; define MOD_ADD_SERIAL_SUB_EN to add op-selected (A - B) mod P
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module mod_add_serial #(
    parameter int               WIDTH   = 381,
    parameter int               DIGIT_W = 64,
    parameter logic [WIDTH-1:0] MODULUS = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MOD_ADD_SERIAL_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int ND = (WIDTH + DIGIT_W - 1) / DIGIT_W;
    localparam int PW = ND * DIGIT_W;
    localparam int CW = ND > 1 ? $clog2(ND) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [PW-1:0] a_sh, b_sh, p_sh, s_sh, d_sh, s_full, d_full;
    logic [CW-1:0] cnt;
    logic [DIGIT_W-1:0] b_d, s_d, d_d;
    logic [DIGIT_W:0] c;
    logic carry, borrow, sub, op_in, bo, sel, last, accept;
`ifdef MOD_ADD_SERIAL_SUB_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_ready & in_valid;
    assign last      = cnt == CW'(ND - 1);
    assign b_d       = b_sh[DIGIT_W-1:0] ^ {DIGIT_W{sub}};
    assign c[0]      = carry;
    assign s_full    = {s_d, s_sh[PW-1:DIGIT_W]};
    assign d_full    = {d_d, d_sh[PW-1:DIGIT_W]};
    genvar i;
    generate
        for (i = 0; i < DIGIT_W; i = i + 1) begin : g_fa
            full_adder u_fa (.x(a_sh[i]), .y(b_d[i]), .ci(c[i]), .s(s_d[i]), .co(c[i+1]));
        end
    endgenerate
    // correction chain on the current sum digit: subtract P when adding, add P back when subtracting
    always_comb begin
        {bo, d_d} = sub ? {1'b0, s_d} + {1'b0, p_sh[DIGIT_W-1:0]} + (DIGIT_W+1)'(borrow)
                        : {1'b0, s_d} - {1'b0, p_sh[DIGIT_W-1:0]} - (DIGIT_W+1)'(borrow);
        sel = sub ? ~c[DIGIT_W] : c[DIGIT_W] | ~bo;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next-state: accept in IDLE, walk the digits, hold DONE until the consumer takes the result
    always_comb begin
        state_nx = state;
        if (state == IDLE && in_valid) state_nx = CALC;
        else if (state == CALC && last) state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end
    // operand capture, one digit per CALC cycle, final selection latched on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            p_sh   <= '0;
            s_sh   <= '0;
            d_sh   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            sub    <= 1'b0;
            result <= '0;
        end else if (accept) begin
            a_sh   <= PW'(a);
            b_sh   <= PW'(b);
            p_sh   <= PW'(MODULUS);
            cnt    <= '0;
            carry  <= op_in;
            borrow <= 1'b0;
            sub    <= op_in;
        end else if (state == CALC) begin
            a_sh   <= a_sh >> DIGIT_W;
            b_sh   <= b_sh >> DIGIT_W;
            p_sh   <= p_sh >> DIGIT_W;
            s_sh   <= s_full;
            d_sh   <= d_full;
            cnt    <= cnt + CW'(1);
            carry  <= c[DIGIT_W];
            borrow <= bo;
            if (last) result <= sel ? d_full[WIDTH-1:0] : s_full[WIDTH-1:0];
        end
    end
endmodule

// File: doc/mod_add_serial.md
Name: mod_add_serial

Overview:
- Digit-serial modular adder for the BLS12-381 base field: computes (A + B) mod P over NUM_DIGITS clock cycles.
- Each cycle one DIGIT_W-wide ripple chain of full_adder cells adds one digit of A and B. A parallel borrow chain subtracts the matching digit of P.
- Sits directly downstream of the full_adder cells, which it instantiates and sequences.
- Feeds the Fp arithmetic pipeline through a valid/ready handshake.

Parameters:
- WIDTH, 381, operand and result width in bits.
- DIGIT_W, 64, bits processed per cycle (width of one full_adder chain).
- MODULUS, 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab, field prime P.
- NUM_DIGITS (derived), ceil(WIDTH/DIGIT_W) = 6. Operands are zero-padded to NUM_DIGITS*DIGIT_W bits.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, required < P.
- b  input  WIDTH  operand B, required < P.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  (A + B) mod P.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, result = 0.
  - Digit counter = 0; carry and borrow registers = 0.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a and b into shift registers, clear carry and borrow, clear the counter, go to CALC.
- State CALC, one digit per cycle, LSB digit first, in_ready = 0:
  - s_i = a_i + b_i + carry, through DIGIT_W chained full_adder cells. Carry out is registered for the next digit.
  - d_i = s_i - p_i - borrow, through the borrow chain. Borrow out is registered.
  - s_i and d_i are shifted into the S and D registers.
  - After digit NUM_DIGITS-1, go to DONE.
- Final selection, computed on entry to DONE:
  - If final carry = 1 or final borrow = 0, then result = D; otherwise result = S.
  - Exactly one conditional correction is applied. Inputs >= P produce unspecified (but deterministic) results.
- State DONE:
  - out_valid = 1 and result is held stable until out_ready.
  - On out_valid & out_ready: go to IDLE with out_valid = 0.
- Latency: the accept edge, plus NUM_DIGITS CALC cycles, plus one cycle, gives out_valid asserted NUM_DIGITS+1 = 7 cycles after acceptance.
  - No overlap; throughput is one op per NUM_DIGITS+2 cycles minimum.
- Back-pressure: out_ready low in DONE holds result and out_valid indefinitely. in_ready stays 0.
- in_valid outside IDLE is ignored; no operand capture.
- Zero-padded upper bits of the top digit contribute 0. The carry out of the padded top digit is the true carry of the 381-bit sum.
- rst_n asserted mid-CALC or mid-DONE: immediately return to reset values. The partial result is discarded and no out_valid pulse is produced.
- out_valid & out_ready in the same cycle as in_valid: not accepted that cycle. in_ready rises the cycle after the return to IDLE.

Optional Feature:
- Macro MOD_ADD_SERIAL_SUB_EN.
- Defined:
  - Adds port `op  input  1`, sampled with the operands (0 = add, 1 = subtract).
  - Subtract computes (A - B) mod P. The main chain forms A + ~B + 1; the correction chain adds P instead of subtracting it.
  - Result = S + P when the main chain ends with no carry (borrow occurred); otherwise result = S.
  - Same latency as add.
- Undefined: no op port; add only; no extra logic.

Test Plan:
- Reset, then a=1, b=2 -> out_valid exactly 7 cycles after accept, result=3, in_ready=0 throughout.
- a=P-1, b=1 -> result=0 (final borrow 0 selects D).
- a=P-1, b=P-1 -> result=P-2; internal carry out of top digit = 0, borrow = 0, D selected.
- a=0x1_0000_0000_0000_0000 (2^64), b=0xFFFF_FFFF_FFFF_FFFF -> result=2^65-1; verifies inter-digit carry across digits 0/1.
- Hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_valid pulses ignored; release -> IDLE next cycle.
- Assert rst_n=0 at the third CALC cycle -> outputs return to reset values asynchronously; the next op a=5, b=7 gives 12.
- With MOD_ADD_SERIAL_SUB_EN: op=1, a=1, b=2 -> result=P-1; op=1, a=7, b=7 -> result=0.
